// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the MixColumns FSM encoding.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;

  localparam logic [7:0] AES_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column; row r lives in byte r (bits 8r+:8).
module mix_single_column
  import aes_pkg::*;
(
  input  aes_col_t i_col,
  output aes_col_t o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[7:0];
  assign w_a1 = i_col[15:8];
  assign w_a2 = i_col[23:16];
  assign w_a3 = i_col[31:24];

  assign o_col[7:0]   = xtime(w_a0) ^ gf_mul3(w_a1) ^ w_a2 ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ xtime(w_a1) ^ gf_mul3(w_a2) ^ w_a3;
  assign o_col[23:16] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ gf_mul3(w_a3);
  assign o_col[31:24] = gf_mul3(w_a0) ^ w_a1 ^ w_a2 ^ xtime(w_a3);

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns between two FIFOs: pops a state, mixes COLS_PER_CYCLE columns per
// BUSY cycle, then pushes it; bypass states go straight to DONE unchanged.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  aes_state_t in_state,
  input  logic       in_bypass,
  input  logic       in_state_empty,
  output logic       in_state_rd,
  output aes_state_t out_state,
  output logic       out_state_wr,
  input  logic       out_state_full
);

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] CNT_LAST = 2'((4 - COLS_PER_CYCLE) % 4);

  mc_state_e  r_state;
  logic [1:0] r_cnt;
  aes_state_t r_work;

  logic [1:0] w_idx     [COLS_PER_CYCLE];
  aes_col_t   w_col_in  [COLS_PER_CYCLE];
  aes_col_t   w_col_out [COLS_PER_CYCLE];
  aes_state_t w_work_mixed;
  logic       w_pop;
  logic       w_push;

  for (genvar g = 0; g < int'(COLS_PER_CYCLE); g++) begin : g_col
    assign w_idx[g]    = r_cnt + 2'(g);
    assign w_col_in[g] = r_work[{w_idx[g], 5'b0} +: 32];
    mix_single_column u_msc (
      .i_col (w_col_in[g]),
      .o_col (w_col_out[g])
    );
  end

  always_comb begin
    w_work_mixed = r_work;
    for (int i = 0; i < int'(COLS_PER_CYCLE); i++) begin
      w_work_mixed[{w_idx[i], 5'b0} +: 32] = w_col_out[i];
    end
  end

  // Strobes are gated by reset so nothing moves while it is held.
  assign w_push = reset && (r_state == DONE) && !out_state_full;
  assign w_pop  = reset && !in_state_empty &&
                  ((r_state == IDLE) || ((r_state == DONE) && !out_state_full));

  assign in_state_rd  = w_pop;
  assign out_state_wr = w_push;
  assign out_state    = r_work;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_work  <= in_state;
            r_cnt   <= '0;
            r_state <= in_bypass ? DONE : BUSY;
          end
        end
        BUSY: begin
          r_work <= w_work_mixed;
          r_cnt  <= r_cnt + CNT_STEP;
          if (r_cnt == CNT_LAST) r_state <= DONE;
        end
        DONE: begin
          if (w_push) begin
            if (w_pop) begin
              r_work  <= in_state;
              r_cnt   <= '0;
              r_state <= in_bypass ? DONE : BUSY;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter (1, 2 and 4 columns per cycle) and mix_single_column.
module tb_mix_columns_iter;

  logic         clock;
  logic         reset;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         empty;
  logic         full;
  logic         rd1, rd2, rd4;
  logic         wr1, wr2, wr4;
  logic [127:0] out1, out2, out4;
  logic [31:0]  msc_in, msc_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol = 0;
  int rd_cnt1 = 0, rd_cnt2 = 0, rd_cnt4 = 0;
  int wr_cnt1 = 0, wr_cnt2 = 0, wr_cnt4 = 0;
  int rd_cyc1 = 0, rd_cyc2 = 0, rd_cyc4 = 0;
  int wr_cyc1 = 0, wr_cyc2 = 0, wr_cyc4 = 0;
  logic [127:0] wr_dat1, wr_dat2, wr_dat4;
  logic [127:0] wq_dat[$];
  int           wq_cyc[$];
  logic         wq_rd[$];

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clock(clock), .reset(reset), .in_state(in_state), .in_bypass(in_bypass),
    .in_state_empty(empty), .in_state_rd(rd1), .out_state(out1), .out_state_wr(wr1),
    .out_state_full(full)
  );
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clock(clock), .reset(reset), .in_state(in_state), .in_bypass(in_bypass),
    .in_state_empty(empty), .in_state_rd(rd2), .out_state(out2), .out_state_wr(wr2),
    .out_state_full(full)
  );
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clock(clock), .reset(reset), .in_state(in_state), .in_bypass(in_bypass),
    .in_state_empty(empty), .in_state_rd(rd4), .out_state(out4), .out_state_wr(wr4),
    .out_state_full(full)
  );
  mix_single_column u_msc (
    .i_col(msc_in),
    .o_col(msc_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  // Strobes seen at a negedge act on the next rising edge, numbered cyc+1.
  always @(negedge clock) begin
    if ((rd1 || rd2 || rd4) && empty) viol++;
    if ((wr1 || wr2 || wr4) && full) viol++;
    if (rd1) begin rd_cnt1++; rd_cyc1 = cyc + 1; end
    if (rd2) begin rd_cnt2++; rd_cyc2 = cyc + 1; end
    if (rd4) begin rd_cnt4++; rd_cyc4 = cyc + 1; end
    if (wr1) begin
      wr_cnt1++; wr_cyc1 = cyc + 1; wr_dat1 = out1;
      wq_dat.push_back(out1); wq_cyc.push_back(cyc + 1); wq_rd.push_back(rd1);
    end
    if (wr2) begin wr_cnt2++; wr_cyc2 = cyc + 1; wr_dat2 = out2; end
    if (wr4) begin wr_cnt4++; wr_cyc4 = cyc + 1; wr_dat4 = out4; end
  end

  function automatic logic [31:0] bs32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Columns written byte 0 (row 0) first, as in the AES literature.
  function automatic logic [127:0] st(input logic [31:0] c0, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] c3);
    return {bs32(c3), bs32(c2), bs32(c1), bs32(c0)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0]  col_in  [9];
  logic [31:0]  col_out [9];
  logic [127:0] x_in, x_out;
  logic [127:0] s_in  [8];
  logic [127:0] s_out [8];
  logic [127:0] q[$];
  logic         rd_now;
  int           b1, b2, b4, br;

  initial begin
    col_in  = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5, 32'h2d26314c,
                32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
    col_out = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6, 32'h4d7ebdf8,
                32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c};
    x_in  = st(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
    x_out = st(32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c);

    reset = 1'b0; in_state = '0; in_bypass = 1'b0; empty = 1'b1; full = 1'b0;
    msc_in = '0;

    // Single-column unit vectors
    for (int i = 0; i < 5; i++) begin
      msc_in = bs32(col_in[i]);
      #1;
      chk("msc_col", msc_out, bs32(col_out[i]));
    end

    // Reset state
    repeat (3) tick();
    chk("rst_out1", out1, 0);
    chk("rst_out2", out2, 0);
    chk("rst_out4", out4, 0);
    chk("rst_wr1", wr1, 0);
    in_state = x_in; empty = 1'b0;
    #1;
    chk("rst_rd_gated", rd1, 0);
    reset = 1'b1;
    #1;
    chk("idle_rd", rd1, 1);

    // Normal state through all three widths
    b1 = wr_cnt1; b2 = wr_cnt2; b4 = wr_cnt4;
    tick();
    empty = 1'b1;
    repeat (8) tick();
    chk("norm_wr_cnt1", wr_cnt1 - b1, 1);
    chk("norm_wr_cnt2", wr_cnt2 - b2, 1);
    chk("norm_wr_cnt4", wr_cnt4 - b4, 1);
    chk("norm_lat1", wr_cyc1 - rd_cyc1, 5);
    chk("norm_lat2", wr_cyc2 - rd_cyc2, 3);
    chk("norm_lat4", wr_cyc4 - rd_cyc4, 2);
    chk("norm_dat1", wr_dat1, x_out);
    chk("norm_dat2", wr_dat2, x_out);
    chk("norm_dat4", wr_dat4, x_out);

    // Bypass
    b1 = wr_cnt1; b4 = wr_cnt4;
    in_state = x_in; in_bypass = 1'b1; empty = 1'b0;
    tick();
    empty = 1'b1; in_bypass = 1'b0;
    repeat (3) tick();
    chk("byp_wr_cnt1", wr_cnt1 - b1, 1);
    chk("byp_lat1", wr_cyc1 - rd_cyc1, 1);
    chk("byp_dat1", wr_dat1, x_in);
    chk("byp_lat4", wr_cyc4 - rd_cyc4, 1);
    chk("byp_dat4", wr_dat4, x_in);

    // Backpressure: hold full across DONE
    b1 = wr_cnt1;
    full = 1'b1; in_state = x_in; empty = 1'b0;
    tick();
    empty = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_wr_low", wr1, 0);
      chk("bp_out_hold", out1, x_out);
      tick();
    end
    chk("bp_no_push", wr_cnt1 - b1, 0);
    br = rd_cnt1;
    full = 1'b0;
    repeat (3) tick();
    chk("bp_release_wr", wr_cnt1 - b1, 1);
    chk("bp_release_dat", wr_dat1, x_out);
    chk("bp_no_rd", rd_cnt1 - br, 0);

    // Streaming 8 states through the 1-column instance
    repeat (4) tick();
    for (int j = 0; j < 8; j++) begin
      s_in[j]  = st(col_in[j % 9], col_in[(j + 1) % 9], col_in[(j + 2) % 9],
                    col_in[(j + 3) % 9]);
      s_out[j] = st(col_out[j % 9], col_out[(j + 1) % 9], col_out[(j + 2) % 9],
                    col_out[(j + 3) % 9]);
      q.push_back(s_in[j]);
    end
    wq_dat.delete(); wq_cyc.delete(); wq_rd.delete();
    for (int n = 0; n < 100 && wq_dat.size() < 8; n++) begin
      empty    = (q.size() == 0);
      in_state = empty ? '0 : q[0];
      @(negedge clock);
      rd_now = rd1;
      tick();
      if (rd_now && q.size() > 0) void'(q.pop_front());
    end
    empty = 1'b1;
    chk("stream_count", wq_dat.size(), 8);
    for (int j = 0; j < wq_dat.size() && j < 8; j++) begin
      chk("stream_dat", wq_dat[j], s_out[j]);
      chk("stream_rd_with_wr", wq_rd[j], (j < 7));
      if (j > 0) chk("stream_gap", wq_cyc[j] - wq_cyc[j - 1], 5);
    end

    // Reset in the second BUSY cycle
    repeat (10) tick();
    b1 = wr_cnt1; b2 = wr_cnt2; b4 = wr_cnt4;
    in_state = x_in; empty = 1'b0;
    tick();
    empty = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (8) tick();
    chk("mid_rst_wr1", wr_cnt1 - b1, 0);
    chk("mid_rst_wr2", wr_cnt2 - b2, 0);
    chk("mid_rst_wr4", wr_cnt4 - b4, 0);
    chk("mid_rst_out", out1, 0);
    chk("mid_rst_rd", rd1, 0);
    in_state = x_in; empty = 1'b0;
    tick();
    empty = 1'b1;
    repeat (8) tick();
    chk("post_rst_wr", wr_cnt1 - b1, 1);
    chk("post_rst_lat", wr_cyc1 - rd_cyc1, 5);
    chk("post_rst_dat", wr_dat1, x_out);

    chk("strobe_vs_flag", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
